// File: rtl/sha256_transform_if.sv
// Block-level bus of one SHA-256 compression instance.
// The master drives the round sequencer and block inputs, and the slave returns the digest.
interface sha256_transform_if;
    logic         feedback;
    logic [5:0]   cnt;
    logic [255:0] rx_state;
    logic [511:0] rx_input;
    logic [255:0] tx_hash;

    modport master (
        output feedback, cnt, rx_state, rx_input,
        input  tx_hash
    );

    modport slave (
        input  feedback, cnt, rx_state, rx_input,
        output tx_hash
    );
endinterface

// File: rtl/sha256_transform.sv
// One SHA-256 compression unrolled into 64/LOOP registered stages.
// Each stage recirculates LOOP rounds. The caller owns the cnt/feedback round sequencer.
module sha256_transform #(
    parameter int LOOP = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    sha256_transform_if.slave   bus
);
    localparam int S = 64 / LOOP;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // State word a sits in the low 32 bits, h in the high 32 bits.
    function automatic logic [255:0] round_f(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {h, g, f, e, d, c, b, a} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction

    // The 16-word window slides down by one word and the new schedule word enters at the top.
    function automatic logic [511:0] sched_f(input logic [511:0] w);
        logic [31:0] w0, w1, w9, w14, w16;
        w0  = w[31:0];
        w1  = w[63:32];
        w9  = w[319:288];
        w14 = w[479:448];
        w16 = (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10)) + w9
            + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + w0;
        return {w16, w[511:32]};
    endfunction

    logic [255:0] state_q [S];
    logic [255:0] state_d [S];
    logic [511:0] w_q [S];
    logic [511:0] w_d [S];
    logic [255:0] tx_hash_q;
    logic [255:0] tx_hash_d;

    logic [255:0] src_s;
    logic [255:0] prev_s;
    logic [511:0] src_w;
    logic [511:0] prev_w;
    logic [5:0]   rnd;

    // prev_* carries the predecessor stage, so stage 0 sees the block inputs.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        src_s   = '0;
        src_w   = '0;
        rnd     = '0;
        prev_s  = bus.rx_state;
        prev_w  = bus.rx_input;
        for (int i = 0; i < S; i++) begin
            src_s      = bus.feedback ? state_q[i] : prev_s;
            src_w      = bus.feedback ? w_q[i] : prev_w;
            rnd        = 6'(LOOP * i) + bus.cnt;
            state_d[i] = round_f(src_s, K[rnd], src_w[31:0]);
            w_d[i]     = sched_f(src_w);
            prev_s     = state_q[i];
            prev_w     = w_q[i];
        end
    end

    always_comb begin
        tx_hash_d = tx_hash_q;
        if (!bus.feedback) begin
            for (int j = 0; j < 8; j++) begin
                tx_hash_d[32*j +: 32] = bus.rx_state[32*j +: 32] + state_q[S-1][32*j +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < S; i++) begin
                state_q[i] <= '0;
                w_q[i]     <= '0;
            end
            tx_hash_q <= '0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            tx_hash_q <= tx_hash_d;
        end
    end

    assign bus.tx_hash = tx_hash_q;

endmodule

// File: tb/tb_sha256_transform.sv
// Bench for sha256_transform: a LOOP=1 streaming instance and a chained LOOP=32 pair.
// All instances are checked against a software SHA-256 compression model.
module tb_sha256_transform;
    localparam logic [255:0] IV        = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] ABC_DIG   = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] EMPTY_DIG = 256'h7852b855_a495991b_649b934c_27ae41e4_996fb924_9afbf4c8_98fc1c14_e3b0c442;
    localparam logic [511:0] ABC_BLK   = {32'h00000018, 448'h0, 32'h61626380};
    localparam logic [511:0] EMPTY_BLK = {480'h0, 32'h80000000};

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sha256_transform_if if_l1 ();
    sha256_transform_if if_c1 ();
    sha256_transform_if if_c2 ();

    sha256_transform #(.LOOP(1))  u_l1 (.clk(clk), .reset_n(reset_n), .bus(if_l1));
    sha256_transform #(.LOOP(32)) u_c1 (.clk(clk), .reset_n(reset_n), .bus(if_c1));
    sha256_transform #(.LOOP(32)) u_c2 (.clk(clk), .reset_n(reset_n), .bus(if_c2));

    assign if_c2.rx_input = {32'h00000100, 192'h0, 32'h80000000, if_c1.tx_hash};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int j = 0; j < 16; j++) w[j] = blk[32*j +: 32];
        for (int j = 16; j < 64; j++)
            w[j] = (rr(w[j-2], 17) ^ rr(w[j-2], 19) ^ (w[j-2] >> 10)) + w[j-7]
                 + (rr(w[j-15], 7) ^ rr(w[j-15], 18) ^ (w[j-15] >> 3)) + w[j-16];
        for (int j = 0; j < 8; j++) v[j] = st[32*j +: 32];
        for (int r = 0; r < 64; r++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r] + w[r];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) res[32*j +: 32] = st[32*j +: 32] + v[j];
        return res;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int t);
        logic [511:0] b;
        if (t < 22) return (t % 2 == 0) ? ABC_BLK : EMPTY_BLK;
        if (t % 5 == 0) return {512{1'b1}};
        if (t % 5 == 1) return '0;
        for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom();
        return b;
    endfunction

    logic [255:0] abc_model;
    logic [255:0] empty_model;
    logic [255:0] dbl_model;

    // Per-edge record of what the LOOP=1 instance loaded.
    logic [511:0] hist_in  [1024];
    bit           hist_vld [1024];
    int           ecount  = 0;
    int           c_loads = 0;

    always @(posedge clk) begin
        hist_in[10'(ecount)]  = if_l1.rx_input;
        hist_vld[10'(ecount)] = reset_n;
        if (reset_n && !if_c1.feedback) c_loads++;
        ecount++;
    end

    always @(negedge reset_n) begin
        for (int i = 0; i < 1024; i++) hist_vld[i] = 1'b0;
        c_loads = 0;
    end

    always @(negedge clk) begin : cmp
        int n;
        n = ecount - 1;
        if (reset_n) begin
            if (n >= 64 && hist_vld[10'(n - 64)])
                check("l1_stream", if_l1.tx_hash, sha_compress(IV, hist_in[10'(n - 64)]));
            if (c_loads >= 3) check("c1_abc", if_c1.tx_hash, abc_model);
            if (c_loads >= 6) check("c2_double", if_c2.tx_hash, dbl_model);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (reset_n) begin
            if_c1.cnt      = (if_c1.cnt == 6'd31) ? 6'd0 : if_c1.cnt + 6'd1;
            if_c1.feedback = (if_c1.cnt != 6'd0);
            if_c2.cnt      = if_c1.cnt;
            if_c2.feedback = if_c1.feedback;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_l1.feedback = 1'b0; if_l1.cnt = 6'd0; if_l1.rx_state = IV; if_l1.rx_input = ABC_BLK;
        if_c1.feedback = 1'b0; if_c1.cnt = 6'd0; if_c1.rx_state = IV; if_c1.rx_input = ABC_BLK;
        if_c2.feedback = 1'b0; if_c2.cnt = 6'd0; if_c2.rx_state = IV;

        abc_model   = sha_compress(IV, ABC_BLK);
        empty_model = sha_compress(IV, EMPTY_BLK);
        dbl_model   = sha_compress(IV, {32'h00000100, 192'h0, 32'h80000000, abc_model});
        check("model_abc", abc_model, ABC_DIG);
        check("model_empty", empty_model, EMPTY_DIG);

        #12;
        check("rst_l1", if_l1.tx_hash, 256'h0);
        check("rst_c1", if_c1.tx_hash, 256'h0);
        check("rst_c2", if_c2.tx_hash, 256'h0);

        @(negedge clk);
        reset_n = 1'b1;
        if_l1.rx_input = pat(0);
        for (int e = 0; e < 200; e++) begin
            tick();
            if (e == 64) begin
                check("lit_l1_abc", if_l1.tx_hash, ABC_DIG);
                check("lit_c1_abc", if_c1.tx_hash, ABC_DIG);
            end
            if (e == 65) check("lit_l1_empty", if_l1.tx_hash, EMPTY_DIG);
            if (e == 84) check("lit_l1_abc_stream", if_l1.tx_hash, ABC_DIG);
            if (e == 85) check("lit_l1_empty_stream", if_l1.tx_hash, EMPTY_DIG);
            if (e == 80) check("lit_c1_hold", if_c1.tx_hash, ABC_DIG);
            if (e == 170) check("c2_double_direct", if_c2.tx_hash, dbl_model);
            if_l1.rx_input = pat(e + 1);
        end

        // Park mid-block at round 30 of the LOOP=32 pair, then reset between edges.
        for (int e = 0; e < 40 && if_c1.cnt != 6'd30; e++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_l1", if_l1.tx_hash, 256'h0);
        check("async_rst_c1", if_c1.tx_hash, 256'h0);
        check("async_rst_c2", if_c2.tx_hash, 256'h0);
        if_c1.cnt = 6'd0; if_c1.feedback = 1'b0;
        if_c2.cnt = 6'd0; if_c2.feedback = 1'b0;
        if_l1.rx_input = ABC_BLK;
        tick();
        tick();
        check("rst_hold_l1", if_l1.tx_hash, 256'h0);
        check("rst_hold_c2", if_c2.tx_hash, 256'h0);
        reset_n = 1'b1;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (e == 63) check("post_rst_l1_early", (if_l1.tx_hash == ABC_DIG) ? 256'h1 : 256'h0, 256'h0);
            if (e == 64) begin
                check("post_rst_l1_abc", if_l1.tx_hash, ABC_DIG);
                check("post_rst_c1_abc", if_c1.tx_hash, ABC_DIG);
            end
            if_l1.rx_input = pat(e + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
